fifo_traffic_ctrl: RTL and testbench

//  Sequences write/read traffic into the dual-flag FIFO on the bring-up board.
//  A prescaled tick paces operations; an FSM fills then drains the FIFO, or

---
 rtl/fifo_traffic_ctrl.sv | 157 +++++++++++++++
 tb/tb_fifo_traffic_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_traffic_ctrl.sv
// rtl/fifo_traffic_ctrl.sv - tick-paced fill/drain or interleaved FIFO traffic sequencer
// Optional read-data checker enabled by defining FIFO_TRAFFIC_CHECK_EN.
module fifo_traffic_ctrl #(
    parameter int DATA_W   = 3,
    parameter int TICK_DIV = 8388608,
    parameter int NUM_OPS  = 16
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic              start,
    input  logic              mode,
    input  logic              f_full,
    input  logic              f_empty,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wr_en,
    output logic              rd_en,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic [7:0]        err_cnt
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int OPS_W = $clog2(NUM_OPS + 1);

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_ILV, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  tick_cnt_q, tick_cnt_d;
    logic [OPS_W-1:0]  op_cnt_q, op_cnt_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              tick;
    logic              clear_run;

    assign tick    = (tick_cnt_q == CNT_W'(TICK_DIV - 1));
    assign wr_data = wr_data_q;

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick ? '0 : tick_cnt_q + CNT_W'(1);
        op_cnt_d   = op_cnt_q;
        wr_data_d  = wr_data_q;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        clear_run  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = mode ? S_ILV : S_WRITE;
                    tick_cnt_d = '0;
                    op_cnt_d   = '0;
                    wr_data_d  = '0;
                    clear_run  = 1'b1;
                end
            end
            S_WRITE: begin
                busy = 1'b1;
                if (tick) begin
                    if (f_full) begin
                        state_d = S_READ;
                    end else begin
                        wr_en     = 1'b1;
                        wr_data_d = wr_data_q + DATA_W'(1);
                    end
                end
            end
            S_READ: begin
                busy = 1'b1;
                if (tick) begin
                    if (f_empty) state_d = S_DONE;
                    else         rd_en   = 1'b1;
                end
            end
            S_ILV: begin
                busy = 1'b1;
                if (tick) begin
                    op_cnt_d = op_cnt_q + OPS_W'(1);
                    // Blocked slots still consume an op so the run length is fixed.
                    if (!op_cnt_q[0]) begin
                        if (!f_full) begin
                            wr_en     = 1'b1;
                            wr_data_d = wr_data_q + DATA_W'(1);
                        end
                    end else if (!f_empty) begin
                        rd_en = 1'b1;
                    end
                    if (op_cnt_q == OPS_W'(NUM_OPS - 1)) state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Reset wins over a coincident tick: no strobe escapes in the reset cycle.
        if (reset_in) begin
            wr_en = 1'b0;
            rd_en = 1'b0;
            done  = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q    <= S_IDLE;
            tick_cnt_q <= '0;
            op_cnt_q   <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            op_cnt_q   <= op_cnt_d;
            wr_data_q  <= wr_data_d;
        end
    end

`ifdef FIFO_TRAFFIC_CHECK_EN
    logic [DATA_W-1:0] exp_data_q, exp_data_d;
    logic              rd_pend_q, rd_pend_d;
    logic [7:0]        err_cnt_q, err_cnt_d;

    always_comb begin
        rd_pend_d  = rd_en;
        exp_data_d = exp_data_q;
        err_cnt_d  = err_cnt_q;
        if (clear_run) begin
            exp_data_d = '0;
            err_cnt_d  = '0;
        end else if (rd_pend_q) begin
            exp_data_d = exp_data_q + DATA_W'(1);
            if (rd_data != exp_data_q && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            exp_data_q <= '0;
            rd_pend_q  <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            exp_data_q <= exp_data_d;
            rd_pend_q  <= rd_pend_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    logic unused_chk;
    assign unused_chk = ^{rd_data, clear_run};
    assign err_cnt    = '0;
`endif

endmodule

// File: tb/tb_fifo_traffic_ctrl.sv
// tb/tb_fifo_traffic_ctrl.sv - directed bench for fifo_traffic_ctrl with a depth-8 FIFO model
module tb_fifo_traffic_ctrl;
    localparam int DW = 3;
`ifdef FIFO_TRAFFIC_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_in = 1'b1, start = 1'b0, mode = 1'b0;
    logic f_full, f_empty, wr_en, rd_en, busy, done;
    logic [DW-1:0] rd_data, wr_data;
    logic [7:0] err_cnt;

    fifo_traffic_ctrl #(.DATA_W(DW), .TICK_DIV(4), .NUM_OPS(16)) dut (
        .clk_in(clk), .reset_in(reset_in), .start(start), .mode(mode),
        .f_full(f_full), .f_empty(f_empty), .rd_data(rd_data),
        .wr_en(wr_en), .rd_en(rd_en), .wr_data(wr_data),
        .busy(busy), .done(done), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model, depth 8, registered read data, with fault injection on the read path
    logic [DW-1:0] mem [8];
    logic [DW-1:0] rdq = '0;
    int  wp = 0, rp = 0, cnt = 0, rd_total = 0;
    bit  force_full = 0, force_not_empty = 0, corrupt_all = 0;
    int  corrupt_idx = -1, rd_base = 0;
    assign f_full  = (cnt == 8) || force_full;
    assign f_empty = (cnt == 0) && !force_not_empty;
    assign rd_data = rdq;

    always @(posedge clk) begin
        int k;
        logic [DW-1:0] kk;
        if (reset_in) begin
            wp <= 0; rp <= 0; cnt <= 0; rdq <= '0;
        end else begin
            k  = rd_total - rd_base;
            kk = k[DW-1:0];
            if (wr_en && cnt < 8) begin mem[wp] <= wr_data; wp <= (wp + 1) % 8; end
            if (rd_en) begin
                rd_total <= rd_total + 1;
                if (corrupt_all) rdq <= kk ^ 3'b001;
                else             rdq <= mem[rp] ^ ((k == corrupt_idx) ? 3'b001 : 3'b000);
                if (cnt > 0) rp <= (rp + 1) % 8;
            end
            cnt <= cnt + ((wr_en && cnt < 8) ? 1 : 0) - ((rd_en && cnt > 0) ? 1 : 0);
        end
    end

    // Event monitor
    logic [DW-1:0] wr_log [$];
    int wr_cyc [$];
    int rd_cnt = 0, both_cnt = 0, done_cnt = 0, done_cyc = -1;
    always @(negedge clk) begin
        if (wr_en) begin wr_log.push_back(wr_data); wr_cyc.push_back(cyc); end
        if (rd_en) rd_cnt++;
        if (wr_en && rd_en) both_cnt++;
        if (done) begin done_cnt++; done_cyc = cyc; end
    end

    int s_cyc, wb, rb;

    task automatic start_run(input logic m);
        @(posedge clk); #1;
        mode = m; start = 1'b1; s_cyc = cyc;
        wb = wr_log.size(); rb = rd_cnt; rd_base = rd_total;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int d0;
        d0 = done_cnt; ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (done_cnt != d0) ok = 1;
        end
    endtask

    task automatic test_reset();
        reset_in = 1'b1; start = 1'b1; mode = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if ({wr_en, rd_en, busy, done} !== 4'b0000) begin errors++; $display("FAIL rst_ctrl: got %b expected 0000", {wr_en, rd_en, busy, done}); end
        checks++; if (wr_data !== 3'd0) begin errors++; $display("FAIL rst_wr_data: got %0d expected 0", wr_data); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL rst_err_cnt: got %0d expected 0", err_cnt); end
        @(posedge clk); #1;
        reset_in = 1'b0; start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_idle: got %0d expected 0", busy); end
    endtask

    task automatic test_fill_drain();
        bit ok; int bad;
        start_run(1'b0);
        wait_done(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL fd_done_timeout: got 0 expected 1"); end
        checks++; if (wr_log.size() - wb !== 8) begin errors++; $display("FAIL fd_wr_count: got %0d expected 8", wr_log.size() - wb); end
        for (int i = 0; i < 8 && wb + i < wr_log.size(); i++) begin
            checks++; if (wr_log[wb + i] !== 3'(i)) begin errors++; $display("FAIL fd_wr_data[%0d]: got %0d expected %0d", i, wr_log[wb + i], i); end
        end
        bad = 0;
        for (int i = 0; i < 8 && wb + i < wr_cyc.size(); i++)
            if (wr_cyc[wb + i] != s_cyc + 4 + 4 * i) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL fd_wr_spacing: got %0d misplaced expected 0", bad); end
        checks++; if (rd_cnt - rb !== 8) begin errors++; $display("FAIL fd_rd_count: got %0d expected 8", rd_cnt - rb); end
        checks++; if (done_cyc !== s_cyc + 73) begin errors++; $display("FAIL fd_done_cycle: got %0d expected %0d", done_cyc - s_cyc, 73); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL fd_err_cnt: got %0d expected 0", err_cnt); end
        checks++; if (cnt !== 0) begin errors++; $display("FAIL fd_fifo_level: got %0d expected 0", cnt); end
    endtask

    task automatic test_interleave();
        bit ok; int bad;
        start_run(1'b1);
        wait_done(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ilv_done_timeout: got 0 expected 1"); end
        checks++; if (wr_log.size() - wb !== 8) begin errors++; $display("FAIL ilv_wr_count: got %0d expected 8", wr_log.size() - wb); end
        checks++; if (rd_cnt - rb !== 8) begin errors++; $display("FAIL ilv_rd_count: got %0d expected 8", rd_cnt - rb); end
        bad = 0;
        for (int i = 0; i < 8 && wb + i < wr_log.size(); i++)
            if (wr_log[wb + i] !== 3'(i) || wr_cyc[wb + i] != s_cyc + 4 + 8 * i) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL ilv_wr_pattern: got %0d wrong writes expected 0", bad); end
        checks++; if (done_cyc !== s_cyc + 65) begin errors++; $display("FAIL ilv_done_cycle: got %0d expected 65", done_cyc - s_cyc); end
        checks++; if (cnt !== 0) begin errors++; $display("FAIL ilv_fifo_level: got %0d expected 0", cnt); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL ilv_err_cnt: got %0d expected 0", err_cnt); end
    endtask

    task automatic test_err_inject();
        bit ok;
        corrupt_idx = 2;
        start_run(1'b0);
        wait_done(200, ok);
        corrupt_idx = -1;
        checks++; if (!ok) begin errors++; $display("FAIL inj_done_timeout: got 0 expected 1"); end
        checks++; if (err_cnt !== (CHK ? 8'd1 : 8'd0)) begin errors++; $display("FAIL inj_err_cnt: got %0d expected %0d", err_cnt, CHK ? 1 : 0); end
    endtask

    task automatic test_saturate();
        bit ok;
        corrupt_all = 1; force_not_empty = 1;
        start_run(1'b0);
        for (int i = 0; i < 3000 && rd_cnt - rb < 300; i++) @(negedge clk);
        @(posedge clk); #1;
        force_not_empty = 0;
        wait_done(50, ok);
        corrupt_all = 0;
        checks++; if (!ok) begin errors++; $display("FAIL sat_done_timeout: got 0 expected 1"); end
        checks++; if (rd_cnt - rb !== 300) begin errors++; $display("FAIL sat_rd_count: got %0d expected 300", rd_cnt - rb); end
        checks++; if (err_cnt !== (CHK ? 8'd255 : 8'd0)) begin errors++; $display("FAIL sat_err_cnt: got %0d expected %0d", err_cnt, CHK ? 255 : 0); end
    endtask

    task automatic test_mid_reset();
        bit ok;
        start_run(1'b0);
        repeat (s_cyc + 12 - cyc) @(posedge clk);
        #1 reset_in = 1'b1;
        @(negedge clk);
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL mrst_strobe: got %0d expected 0", wr_en); end
        checks++; if (wr_log.size() - wb !== 2) begin errors++; $display("FAIL mrst_pre_writes: got %0d expected 2", wr_log.size() - wb); end
        @(posedge clk); #1 reset_in = 1'b0;
        @(negedge clk);
        checks++; if ({busy, wr_en, rd_en, done} !== 4'b0000) begin errors++; $display("FAIL mrst_ctrl: got %b expected 0000", {busy, wr_en, rd_en, done}); end
        checks++; if (wr_data !== 3'd0) begin errors++; $display("FAIL mrst_wr_data: got %0d expected 0", wr_data); end
        start_run(1'b0);
        wait_done(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL mrst_done_timeout: got 0 expected 1"); end
        checks++; if (wr_log.size() - wb !== 8 || wr_log[wb] !== 3'd0 || wr_cyc[wb] != s_cyc + 4) begin
            errors++; $display("FAIL mrst_restart: got %0d writes expected 8 starting at 0", wr_log.size() - wb); end
    endtask

    task automatic test_back_to_back();
        bit ok; int bad, d1, wb2;
        start_run(1'b0);
        repeat (9) @(posedge clk);
        #1 start = 1'b1; mode = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_done_timeout: got 0 expected 1"); end
        bad = 0;
        for (int i = 0; i < 8 && wb + i < wr_cyc.size(); i++)
            if (wr_cyc[wb + i] != s_cyc + 4 + 4 * i) bad++;
        checks++; if (bad !== 0 || wr_log.size() - wb !== 8) begin errors++; $display("FAIL b2b_busy_start: got %0d misplaced of %0d expected 0 of 8", bad, wr_log.size() - wb); end
        checks++; if (done_cyc !== s_cyc + 73) begin errors++; $display("FAIL b2b_done_cycle: got %0d expected 73", done_cyc - s_cyc); end
        @(posedge clk); #1;
        mode = 1'b0; start = 1'b1;
        wait_done(200, ok);
        d1 = done_cyc; wb2 = wr_log.size();
        repeat (2) @(posedge clk);
        #1 start = 1'b0;
        wait_done(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_rerun_timeout: got 0 expected 1"); end
        checks++; if (wr_log.size() - wb2 !== 8 || wr_cyc[wb2] != d1 + 5) begin
            errors++; $display("FAIL b2b_rerun_first_wr: got %0d writes expected 8", wr_log.size() - wb2); end
        checks++; if (done_cyc !== d1 + 74) begin errors++; $display("FAIL b2b_rerun_done: got %0d expected 74", done_cyc - d1); end
    endtask

    task automatic test_ilv_full();
        bit ok;
        force_full = 1;
        start_run(1'b1);
        wait_done(200, ok);
        force_full = 0;
        checks++; if (!ok) begin errors++; $display("FAIL ilvf_done_timeout: got 0 expected 1"); end
        checks++; if (wr_log.size() - wb !== 0 || rd_cnt - rb !== 0) begin errors++; $display("FAIL ilvf_strobes: got %0d wr %0d rd expected 0 0", wr_log.size() - wb, rd_cnt - rb); end
        checks++; if (done_cyc !== s_cyc + 65) begin errors++; $display("FAIL ilvf_done_cycle: got %0d expected 65", done_cyc - s_cyc); end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_interleave();
        test_err_inject();
        test_saturate();
        test_mid_reset();
        test_back_to_back();
        test_ilv_full();
        checks++; if (both_cnt !== 0) begin errors++; $display("FAIL strobe_overlap: got %0d expected 0", both_cnt); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
